rs_wakeup_select: RTL and testbench
===================================

RS_WAKEUP_SELECT -- requirements
Module: rs_wakeup_select

Interface
REQ-001 Parameter ENT_NUM, default 8, number of reservation-station entries.
REQ-002 Parameter ENT_SEL, default 3, entry index width, equal to log2(ENT_NUM).
REQ-003 Parameter PAY_W, default 64, opaque per-entry payload width (opcode, immediates, PC).
REQ-004 Port widths `PHY_REG_SEL and `MAX_LATENCY come from constants.vh.
REQ-005 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-006 Clock and reset ports:
- clk  in  1  clock.
- reset  in  1  asynchronous active-low reset.
REQ-007 Dispatch ports, suffix _k for k = 1, 2:
- dispatch_k  in  1  write one entry.
- src1_k, src2_k, dst_k  in  `PHY_REG_SEL  source and destination tags.
- wr_reg_k  in  1  instruction writes dst.
- payload_k  in  PAY_W  opaque payload.
REQ-008 Scoreboard inputs, one per source j = 1, 2 and port k = 1, 2:
- matchj_k  in  1  match bit.
- shift_rj_k  in  `MAX_LATENCY  readiness shift register.
- delayj_k  in  `MAX_LATENCY  latency vector.
REQ-009 Broadcast inputs, n = 1..3:
- broadcast_enable_n  in  1  tag valid.
- broadcast_tag_n  in  `PHY_REG_SEL  completing tag.
REQ-010 Control and status:
- issue_stall  in  1  execution unit cannot accept.
- flush  in  1  kill all entries.
- allocatable  out  1  two or more entries free.
REQ-011 Issue outputs:
- issue_valid  out  1  entry issued this cycle.
- issue_dst  out  `PHY_REG_SEL  issued dst tag.
- issue_wr_reg  out  1  issued wr_reg.
- issue_src1, issue_src2  out  `PHY_REG_SEL  issued source tags.
- issue_payload  out  PAY_W  issued payload.

Function
REQ-012 Each entry SHALL hold valid, src tags, dst, wr_reg, payload, and per-source match, shift_r and delay.
REQ-013 A source SHALL be ready when its shift_r[0] is 1; an entry SHALL be ready when valid and both sources are ready.
REQ-014 Dispatch writes:
- Free entries are those with valid = 0 at the current edge.
- dispatch_1 SHALL write the lowest-index free entry.
- dispatch_2 SHALL write the next-lowest free entry, or the lowest if dispatch_1 = 0.
- Each write loads the scoreboard values exactly as presented.
REQ-015 allocatable SHALL be combinational: 1 iff two or more entries have valid = 0.
REQ-016 Dispatch while allocatable = 0 is illegal; the RTL SHALL assert on it in simulation.
REQ-017 Wakeup: at each posedge, for each valid source not written this cycle, the first matching rule below SHALL apply.
- If any enabled broadcast_tag_n equals the source tag, set match = 1 and shift_r = delay.
- Else if match = 1 and shift_r[0] = 0, shift_r SHALL arithmetic-shift right by 1, replicating the MSB.
- Otherwise shift_r holds.
REQ-018 An entry written by dispatch in a cycle SHALL NOT apply that cycle's broadcast or shift; the scoreboard already forwards same-cycle broadcasts.
REQ-019 Select: when issue_stall = 0, the lowest-index ready entry SHALL be selected; there is no age ordering.
REQ-020 Issue outputs SHALL be registered:
- At the edge of selection, issue_valid = 1 and the issue_* fields are loaded from the entry.
- The entry's valid clears at the same edge.
- Latency from entry-ready to issue_valid is 1 cycle.
REQ-021 issue_valid SHALL be 0 in any cycle following an edge with no selection (stall, no ready entry, or flush).
REQ-022 A freed entry SHALL NOT be re-allocated in the same cycle it issues.
REQ-023 flush SHALL clear all entry valid bits and issue_valid at the next edge, overriding dispatch and select in that cycle.
REQ-024 Simultaneous broadcasts of the same tag on several ports SHALL be equivalent to a single broadcast.

Reset
REQ-025 While reset = 0:
- All entry valid, match and shift_r bits and every output register SHALL be 0.
- allocatable SHALL be 1.
REQ-026 Deassertion of reset SHALL take effect at the first posedge after it.
REQ-027 Reset asserted mid-operation SHALL discard all entries immediately, without waiting for a clock edge.

Verification (MAX_LATENCY = 3)
REQ-028 Ready-at-dispatch: dispatch_1 with shift_r1_1 = shift_r2_1 = 3'b111 -> issue_valid = 1 one cycle after dispatch, issue_dst = dst_1.
REQ-029 MUL producer: source waiting with match = 0, then broadcast of its tag with delay 3'b110 -> shift_r 110 then 111; issue_valid 2 cycles after the broadcast edge.
REQ-030 LDST producer: delay 3'b100 -> shift_r 100, 110, 111; issue 3 cycles after the broadcast edge.
REQ-031 Fill and full: 7 dispatches -> allocatable = 0; one issue -> allocatable = 1 the next cycle.
REQ-032 Select conflict: entries 2 and 5 ready with issue_stall = 1 for 2 cycles -> no issue; on release entry 2 issues, then entry 5.
REQ-033 Flush and reset: flush with 4 valid entries -> 0 valid and issue_valid = 0 next cycle; reset pulse mid-wakeup -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/rs_wakeup_select.sv
// Reservation station with tag wakeup and lowest-index issue select.
// Two dispatch slots, three broadcast ports, one registered issue port.
`ifndef PHY_REG_SEL
`define PHY_REG_SEL 6
`endif
`ifndef MAX_LATENCY
`define MAX_LATENCY 3
`endif

module rs_wakeup_select #(
  parameter int ENT_NUM = 8,
  parameter int ENT_SEL = 3,
  parameter int PAY_W   = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      dispatch_1,
  input  logic [`PHY_REG_SEL-1:0]   src1_1,
  input  logic [`PHY_REG_SEL-1:0]   src2_1,
  input  logic [`PHY_REG_SEL-1:0]   dst_1,
  input  logic                      wr_reg_1,
  input  logic [PAY_W-1:0]          payload_1,
  input  logic                      dispatch_2,
  input  logic [`PHY_REG_SEL-1:0]   src1_2,
  input  logic [`PHY_REG_SEL-1:0]   src2_2,
  input  logic [`PHY_REG_SEL-1:0]   dst_2,
  input  logic                      wr_reg_2,
  input  logic [PAY_W-1:0]          payload_2,
  input  logic                      match1_1,
  input  logic [`MAX_LATENCY-1:0]   shift_r1_1,
  input  logic [`MAX_LATENCY-1:0]   delay1_1,
  input  logic                      match2_1,
  input  logic [`MAX_LATENCY-1:0]   shift_r2_1,
  input  logic [`MAX_LATENCY-1:0]   delay2_1,
  input  logic                      match1_2,
  input  logic [`MAX_LATENCY-1:0]   shift_r1_2,
  input  logic [`MAX_LATENCY-1:0]   delay1_2,
  input  logic                      match2_2,
  input  logic [`MAX_LATENCY-1:0]   shift_r2_2,
  input  logic [`MAX_LATENCY-1:0]   delay2_2,
  input  logic                      broadcast_enable_1,
  input  logic [`PHY_REG_SEL-1:0]   broadcast_tag_1,
  input  logic                      broadcast_enable_2,
  input  logic [`PHY_REG_SEL-1:0]   broadcast_tag_2,
  input  logic                      broadcast_enable_3,
  input  logic [`PHY_REG_SEL-1:0]   broadcast_tag_3,
  input  logic                      issue_stall,
  input  logic                      flush,
  output logic                      allocatable,
  output logic                      issue_valid,
  output logic [`PHY_REG_SEL-1:0]   issue_dst,
  output logic                      issue_wr_reg,
  output logic [`PHY_REG_SEL-1:0]   issue_src1,
  output logic [`PHY_REG_SEL-1:0]   issue_src2,
  output logic [PAY_W-1:0]          issue_payload
);

  localparam int TW = `PHY_REG_SEL;
  localparam int LW = `MAX_LATENCY;

  logic [ENT_NUM-1:0] r_valid;
  logic [TW-1:0]      r_src1 [ENT_NUM];
  logic [TW-1:0]      r_src2 [ENT_NUM];
  logic [TW-1:0]      r_dst  [ENT_NUM];
  logic               r_wr   [ENT_NUM];
  logic [PAY_W-1:0]   r_pay  [ENT_NUM];
  logic               r_m1   [ENT_NUM];
  logic               r_m2   [ENT_NUM];
  logic [LW-1:0]      r_sh1  [ENT_NUM];
  logic [LW-1:0]      r_sh2  [ENT_NUM];
  logic [LW-1:0]      r_dl1  [ENT_NUM];
  logic [LW-1:0]      r_dl2  [ENT_NUM];

  logic               r_iss_v;
  logic [TW-1:0]      r_iss_dst;
  logic               r_iss_wr;
  logic [TW-1:0]      r_iss_s1;
  logic [TW-1:0]      r_iss_s2;
  logic [PAY_W-1:0]   r_iss_pay;

  logic [ENT_SEL-1:0] w_f1;
  logic [ENT_SEL-1:0] w_f2;
  logic               w_f1_ok;
  logic               w_f2_ok;
  logic [ENT_SEL-1:0] w_idx2;
  logic [ENT_SEL-1:0] w_sel;
  logic               w_sel_ok;
  logic [ENT_NUM-1:0] w_hit1;
  logic [ENT_NUM-1:0] w_hit2;

  always_comb begin
    w_f1    = '0;
    w_f2    = '0;
    w_f1_ok = 1'b0;
    w_f2_ok = 1'b0;
    for (int i = 0; i < ENT_NUM; i++) begin
      if (!r_valid[i]) begin
        if (!w_f1_ok) begin
          w_f1    = ENT_SEL'(i);
          w_f1_ok = 1'b1;
        end else if (!w_f2_ok) begin
          w_f2    = ENT_SEL'(i);
          w_f2_ok = 1'b1;
        end
      end
    end
  end

  assign allocatable = w_f2_ok;
  assign w_idx2 = dispatch_1 ? w_f2 : w_f1;

  // Oldest-first is not required: lowest ready index wins.
  always_comb begin
    w_sel    = '0;
    w_sel_ok = 1'b0;
    for (int i = 0; i < ENT_NUM; i++) begin
      if (!w_sel_ok && r_valid[i] && r_sh1[i][0] && r_sh2[i][0]) begin
        w_sel    = ENT_SEL'(i);
        w_sel_ok = !issue_stall;
      end
    end
  end

  always_comb begin
    w_hit1 = '0;
    w_hit2 = '0;
    for (int i = 0; i < ENT_NUM; i++) begin
      w_hit1[i] = (broadcast_enable_1 && broadcast_tag_1 == r_src1[i]) ||
                  (broadcast_enable_2 && broadcast_tag_2 == r_src1[i]) ||
                  (broadcast_enable_3 && broadcast_tag_3 == r_src1[i]);
      w_hit2[i] = (broadcast_enable_1 && broadcast_tag_1 == r_src2[i]) ||
                  (broadcast_enable_2 && broadcast_tag_2 == r_src2[i]) ||
                  (broadcast_enable_3 && broadcast_tag_3 == r_src2[i]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid   <= '0;
      r_iss_v   <= 1'b0;
      r_iss_dst <= '0;
      r_iss_wr  <= 1'b0;
      r_iss_s1  <= '0;
      r_iss_s2  <= '0;
      r_iss_pay <= '0;
      for (int i = 0; i < ENT_NUM; i++) begin
        r_src1[i] <= '0;
        r_src2[i] <= '0;
        r_dst[i]  <= '0;
        r_wr[i]   <= 1'b0;
        r_pay[i]  <= '0;
        r_m1[i]   <= 1'b0;
        r_m2[i]   <= 1'b0;
        r_sh1[i]  <= '0;
        r_sh2[i]  <= '0;
        r_dl1[i]  <= '0;
        r_dl2[i]  <= '0;
      end
    end else if (flush) begin
      r_valid <= '0;
      r_iss_v <= 1'b0;
    end else begin
      r_iss_v <= w_sel_ok;
      if (w_sel_ok) begin
        r_valid[w_sel] <= 1'b0;
        r_iss_dst      <= r_dst[w_sel];
        r_iss_wr       <= r_wr[w_sel];
        r_iss_s1       <= r_src1[w_sel];
        r_iss_s2       <= r_src2[w_sel];
        r_iss_pay      <= r_pay[w_sel];
      end
      // Dispatch targets only free slots, so wakeup never collides with it.
      for (int i = 0; i < ENT_NUM; i++) begin
        if (r_valid[i]) begin
          if (w_hit1[i]) begin
            r_m1[i]  <= 1'b1;
            r_sh1[i] <= r_dl1[i];
          end else if (r_m1[i] && !r_sh1[i][0]) begin
            r_sh1[i] <= {r_sh1[i][LW-1], r_sh1[i][LW-1:1]};
          end
          if (w_hit2[i]) begin
            r_m2[i]  <= 1'b1;
            r_sh2[i] <= r_dl2[i];
          end else if (r_m2[i] && !r_sh2[i][0]) begin
            r_sh2[i] <= {r_sh2[i][LW-1], r_sh2[i][LW-1:1]};
          end
        end
      end
      if (dispatch_1) begin
        r_valid[w_f1] <= 1'b1;
        r_src1[w_f1]  <= src1_1;
        r_src2[w_f1]  <= src2_1;
        r_dst[w_f1]   <= dst_1;
        r_wr[w_f1]    <= wr_reg_1;
        r_pay[w_f1]   <= payload_1;
        r_m1[w_f1]    <= match1_1;
        r_m2[w_f1]    <= match2_1;
        r_sh1[w_f1]   <= shift_r1_1;
        r_sh2[w_f1]   <= shift_r2_1;
        r_dl1[w_f1]   <= delay1_1;
        r_dl2[w_f1]   <= delay2_1;
      end
      if (dispatch_2) begin
        r_valid[w_idx2] <= 1'b1;
        r_src1[w_idx2]  <= src1_2;
        r_src2[w_idx2]  <= src2_2;
        r_dst[w_idx2]   <= dst_2;
        r_wr[w_idx2]    <= wr_reg_2;
        r_pay[w_idx2]   <= payload_2;
        r_m1[w_idx2]    <= match1_2;
        r_m2[w_idx2]    <= match2_2;
        r_sh1[w_idx2]   <= shift_r1_2;
        r_sh2[w_idx2]   <= shift_r2_2;
        r_dl1[w_idx2]   <= delay1_2;
        r_dl2[w_idx2]   <= delay2_2;
      end
    end
  end

  assign issue_valid   = r_iss_v;
  assign issue_dst     = r_iss_dst;
  assign issue_wr_reg  = r_iss_wr;
  assign issue_src1    = r_iss_s1;
  assign issue_src2    = r_iss_s2;
  assign issue_payload = r_iss_pay;

  a_disp_full: assert property (@(posedge clk) disable iff (!reset)
    (dispatch_1 || dispatch_2) |-> allocatable);

endmodule

// File: tb/tb_rs_wakeup_select.sv
// Directed bench for rs_wakeup_select: wakeup latency table plus
// fill, select-conflict, flush and async reset sequences.
module tb_rs_wakeup_select;

  logic        clk = 1'b0;
  logic        reset;
  logic        dispatch_1, dispatch_2;
  logic [5:0]  src1_1, src2_1, dst_1, src1_2, src2_2, dst_2;
  logic        wr_reg_1, wr_reg_2;
  logic [63:0] payload_1, payload_2;
  logic        match1_1, match2_1, match1_2, match2_2;
  logic [2:0]  shift_r1_1, shift_r2_1, shift_r1_2, shift_r2_2;
  logic [2:0]  delay1_1, delay2_1, delay1_2, delay2_2;
  logic        broadcast_enable_1, broadcast_enable_2, broadcast_enable_3;
  logic [5:0]  broadcast_tag_1, broadcast_tag_2, broadcast_tag_3;
  logic        issue_stall, flush;
  logic        allocatable, issue_valid, issue_wr_reg;
  logic [5:0]  issue_dst, issue_src1, issue_src2;
  logic [63:0] issue_payload;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rs_wakeup_select #(.ENT_NUM(8), .ENT_SEL(3), .PAY_W(64)) dut (
    .clk(clk), .reset(reset),
    .dispatch_1(dispatch_1), .src1_1(src1_1), .src2_1(src2_1),
    .dst_1(dst_1), .wr_reg_1(wr_reg_1), .payload_1(payload_1),
    .dispatch_2(dispatch_2), .src1_2(src1_2), .src2_2(src2_2),
    .dst_2(dst_2), .wr_reg_2(wr_reg_2), .payload_2(payload_2),
    .match1_1(match1_1), .shift_r1_1(shift_r1_1), .delay1_1(delay1_1),
    .match2_1(match2_1), .shift_r2_1(shift_r2_1), .delay2_1(delay2_1),
    .match1_2(match1_2), .shift_r1_2(shift_r1_2), .delay1_2(delay1_2),
    .match2_2(match2_2), .shift_r2_2(shift_r2_2), .delay2_2(delay2_2),
    .broadcast_enable_1(broadcast_enable_1), .broadcast_tag_1(broadcast_tag_1),
    .broadcast_enable_2(broadcast_enable_2), .broadcast_tag_2(broadcast_tag_2),
    .broadcast_enable_3(broadcast_enable_3), .broadcast_tag_3(broadcast_tag_3),
    .issue_stall(issue_stall), .flush(flush), .allocatable(allocatable),
    .issue_valid(issue_valid), .issue_dst(issue_dst),
    .issue_wr_reg(issue_wr_reg), .issue_src1(issue_src1),
    .issue_src2(issue_src2), .issue_payload(issue_payload)
  );

  typedef struct {
    logic [5:0] s1, s2, dst;
    logic [2:0] sh1, sh2, dl1, dl2;
    logic       m1, m2;
    int         bcw;
    int         bcp;
    logic [5:0] bct;
    int         lat;
  } vec_t;

  vec_t vt [12];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    dispatch_1 = 0; dispatch_2 = 0;
    src1_1 = 0; src2_1 = 0; dst_1 = 0; wr_reg_1 = 0; payload_1 = 0;
    src1_2 = 0; src2_2 = 0; dst_2 = 0; wr_reg_2 = 0; payload_2 = 0;
    match1_1 = 0; match2_1 = 0; match1_2 = 0; match2_2 = 0;
    shift_r1_1 = 0; shift_r2_1 = 0; shift_r1_2 = 0; shift_r2_2 = 0;
    delay1_1 = 0; delay2_1 = 0; delay1_2 = 0; delay2_2 = 0;
    broadcast_enable_1 = 0; broadcast_enable_2 = 0; broadcast_enable_3 = 0;
    broadcast_tag_1 = 0; broadcast_tag_2 = 0; broadcast_tag_3 = 0;
    flush = 0;
  endtask

  task automatic disp(input int k, input logic [5:0] s1, input logic [5:0] s2,
                      input logic [5:0] dst, input logic [2:0] sh1,
                      input logic [2:0] sh2, input logic [2:0] dl1,
                      input logic [2:0] dl2, input logic m1, input logic m2,
                      input logic wr, input logic [63:0] pay);
    if (k == 1) begin
      dispatch_1 = 1; src1_1 = s1; src2_1 = s2; dst_1 = dst;
      shift_r1_1 = sh1; shift_r2_1 = sh2; delay1_1 = dl1; delay2_1 = dl2;
      match1_1 = m1; match2_1 = m2; wr_reg_1 = wr; payload_1 = pay;
    end else begin
      dispatch_2 = 1; src1_2 = s1; src2_2 = s2; dst_2 = dst;
      shift_r1_2 = sh1; shift_r2_2 = sh2; delay1_2 = dl1; delay2_2 = dl2;
      match1_2 = m1; match2_2 = m2; wr_reg_2 = wr; payload_2 = pay;
    end
  endtask

  task automatic bcast(input int p, input logic [5:0] t);
    if (p == 0 || p == 1) begin broadcast_enable_1 = 1; broadcast_tag_1 = t; end
    if (p == 0 || p == 2) begin broadcast_enable_2 = 1; broadcast_tag_2 = t; end
    if (p == 0 || p == 3) begin broadcast_enable_3 = 1; broadcast_tag_3 = t; end
  endtask

  task automatic do_flush();
    flush = 1;
    step();
    flush = 0;
  endtask

  initial begin
    int got;
    int seen;
    logic [5:0]  g_dst, g_s1;
    logic        g_wr;
    logic [63:0] g_pay, pay;

    // s1 s2 dst sh1 sh2 dl1 dl2 m1 m2 bcw bcp bct lat
    vt[0]  = '{6'd1,  6'd2,  6'd3,  3'b111, 3'b111, 3'b000, 3'b000, 1, 1, 0, 0, 6'd0,  1};
    vt[1]  = '{6'd5,  6'd6,  6'd7,  3'b000, 3'b111, 3'b110, 3'b000, 0, 1, 2, 1, 6'd5,  3};
    vt[2]  = '{6'd5,  6'd6,  6'd8,  3'b000, 3'b111, 3'b100, 3'b000, 0, 1, 2, 2, 6'd5,  4};
    vt[3]  = '{6'd5,  6'd6,  6'd9,  3'b000, 3'b111, 3'b001, 3'b000, 0, 1, 2, 3, 6'd5,  2};
    vt[4]  = '{6'd5,  6'd6,  6'd10, 3'b000, 3'b111, 3'b001, 3'b000, 0, 1, 2, 1, 6'd9,  0};
    vt[5]  = '{6'd5,  6'd6,  6'd11, 3'b100, 3'b111, 3'b000, 3'b000, 1, 1, 0, 0, 6'd0,  3};
    vt[6]  = '{6'd5,  6'd6,  6'd12, 3'b110, 3'b111, 3'b000, 3'b000, 1, 1, 0, 0, 6'd0,  2};
    vt[7]  = '{6'd5,  6'd6,  6'd13, 3'b100, 3'b111, 3'b000, 3'b000, 0, 1, 0, 0, 6'd0,  0};
    vt[8]  = '{6'd11, 6'd12, 6'd14, 3'b111, 3'b000, 3'b000, 3'b110, 1, 0, 2, 3, 6'd12, 3};
    vt[9]  = '{6'd14, 6'd14, 6'd15, 3'b000, 3'b000, 3'b100, 3'b100, 0, 0, 2, 0, 6'd14, 4};
    vt[10] = '{6'd5,  6'd6,  6'd16, 3'b000, 3'b111, 3'b001, 3'b000, 0, 1, 1, 1, 6'd5,  0};
    vt[11] = '{6'd5,  6'd6,  6'd17, 3'b000, 3'b111, 3'b111, 3'b000, 0, 1, 2, 2, 6'd5,  2};

    clr_in();
    issue_stall = 0;
    reset = 0;
    step();
    step();
    chk("rst_issue_valid", issue_valid, 0);
    chk("rst_alloc", allocatable, 1);
    @(negedge clk);
    reset = 1;
    step();
    chk("post_rst_issue", issue_valid, 0);

    for (int v = 0; v < 12; v++) begin
      clr_in();
      pay = {32'hCAFE0000 + 32'(v), 32'(v * 3)};
      disp(1, vt[v].s1, vt[v].s2, vt[v].dst, vt[v].sh1, vt[v].sh2,
           vt[v].dl1, vt[v].dl2, vt[v].m1, vt[v].m2, v[0], pay);
      if (vt[v].bcw == 1) bcast(vt[v].bcp, vt[v].bct);
      step();
      clr_in();
      if (vt[v].bcw == 2) bcast(vt[v].bcp, vt[v].bct);
      got = 0;
      g_dst = 0; g_s1 = 0; g_wr = 0; g_pay = 0;
      for (int c = 1; c <= 8; c++) begin
        step();
        clr_in();
        if (issue_valid && got == 0) begin
          got = c;
          g_dst = issue_dst; g_s1 = issue_src1;
          g_wr = issue_wr_reg; g_pay = issue_payload;
        end
      end
      chk($sformatf("v%0d_lat", v), got, vt[v].lat);
      if (vt[v].lat != 0) begin
        chk($sformatf("v%0d_dst", v), g_dst, vt[v].dst);
        chk($sformatf("v%0d_src1", v), g_s1, vt[v].s1);
        chk($sformatf("v%0d_wr", v), g_wr, v[0]);
        chk($sformatf("v%0d_pay", v), g_pay, pay);
      end
      do_flush();
      chk($sformatf("v%0d_flush_alloc", v), allocatable, 1);
    end

    // Fill seven entries, then free one through wakeup.
    clr_in();
    for (int p = 0; p < 3; p++) begin
      disp(1, 6'(30 + 2 * p), 6'd31, 6'(20 + 2 * p), 3'b000, 3'b111,
           3'b111, 3'b000, 0, 1, 0, 64'(2 * p));
      disp(2, 6'(31 + 2 * p), 6'd31, 6'(21 + 2 * p), 3'b000, 3'b111,
           3'b111, 3'b000, 0, 1, 0, 64'(2 * p + 1));
      step();
      clr_in();
    end
    chk("fill6_alloc", allocatable, 1);
    disp(1, 6'd36, 6'd31, 6'd26, 3'b000, 3'b111, 3'b111, 3'b000, 0, 1, 0, 64'd6);
    step();
    clr_in();
    chk("fill7_alloc", allocatable, 0);
    bcast(2, 6'd33);
    step();
    clr_in();
    chk("full_wake_alloc", allocatable, 0);
    chk("full_wake_iv", issue_valid, 0);
    bcast(1, 6'd34);
    step();
    clr_in();
    chk("full_issue_iv", issue_valid, 1);
    chk("full_issue_dst", issue_dst, 6'd23);
    chk("full_issue_alloc", allocatable, 1);
    do_flush();
    chk("flush_iv", issue_valid, 0);
    chk("flush_alloc", allocatable, 1);
    step();
    chk("flush_after_iv", issue_valid, 0);

    // Entries 2 and 5 ready under stall, then release with dispatch.
    clr_in();
    issue_stall = 1;
    for (int p = 0; p < 3; p++) begin
      disp(1, 6'(50 + 2 * p), 6'd31, 6'(40 + 2 * p),
           (2 * p == 2) ? 3'b111 : 3'b000, 3'b111, 3'b111, 3'b000, 0, 1, 0, 0);
      disp(2, 6'(51 + 2 * p), 6'd31, 6'(41 + 2 * p),
           (2 * p + 1 == 5) ? 3'b111 : 3'b000, 3'b111, 3'b111, 3'b000, 0, 1, 0, 0);
      step();
      clr_in();
    end
    step();
    chk("stall1_iv", issue_valid, 0);
    step();
    chk("stall2_iv", issue_valid, 0);
    issue_stall = 0;
    disp(1, 6'd58, 6'd31, 6'd46, 3'b000, 3'b111, 3'b111, 3'b000, 0, 1, 0, 0);
    disp(2, 6'd59, 6'd31, 6'd47, 3'b000, 3'b111, 3'b111, 3'b000, 0, 1, 0, 0);
    step();
    clr_in();
    chk("sel_a_iv", issue_valid, 1);
    chk("sel_a_dst", issue_dst, 6'd42);
    chk("sel_a_noreuse_alloc", allocatable, 0);
    step();
    chk("sel_b_iv", issue_valid, 1);
    chk("sel_b_dst", issue_dst, 6'd45);
    chk("sel_b_alloc", allocatable, 1);
    step();
    chk("sel_c_iv", issue_valid, 0);
    do_flush();

    // Slot order with both dispatch ports and dispatch_2 alone.
    clr_in();
    disp(2, 6'd1, 6'd2, 6'd60, 3'b111, 3'b111, 3'b000, 3'b000, 1, 1, 1, 64'h60);
    step();
    clr_in();
    step();
    chk("d2only_dst", issue_dst, 6'd60);
    chk("d2only_pay", issue_payload, 64'h60);
    disp(1, 6'd1, 6'd2, 6'd61, 3'b111, 3'b111, 3'b000, 3'b000, 1, 1, 0, 0);
    disp(2, 6'd1, 6'd2, 6'd62, 3'b111, 3'b111, 3'b000, 3'b000, 1, 1, 0, 0);
    step();
    clr_in();
    step();
    chk("pair_first_dst", issue_dst, 6'd61);
    step();
    chk("pair_second_dst", issue_dst, 6'd62);
    step();

    // Async reset while an entry is mid-wakeup.
    clr_in();
    disp(1, 6'd1, 6'd2, 6'd70, 3'b111, 3'b111, 3'b000, 3'b000, 1, 1, 1, 64'h70);
    disp(2, 6'd63, 6'd2, 6'd72, 3'b000, 3'b111, 3'b100, 3'b000, 0, 1, 1, 64'h72);
    step();
    clr_in();
    bcast(1, 6'd63);
    step();
    clr_in();
    chk("pre_rst_iv", issue_valid, 1);
    chk("pre_rst_dst", issue_dst, 6'd70);
    reset = 0;
    #1;
    chk("async_rst_iv", issue_valid, 0);
    chk("async_rst_dst", issue_dst, 0);
    chk("async_rst_pay", issue_payload, 0);
    chk("async_rst_alloc", allocatable, 1);
    @(negedge clk);
    reset = 1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (issue_valid) seen++;
    end
    chk("rst_discard", seen, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
